fp_addsub_arbiter: RTL and testbench

Shares one combinational FP_Adder_Subtractor instance among NUM_REQ requesters with round-robin arbitration. Only one operation is in flight at a time. Each grant captures the requester's operands into registers that drive the unit. The block waits LAT cycles for the unit to settle, then registers the result and flags into a response buffer tagged with the requester id. It also keeps a sticky exception-flag register, the accrued-flags source for the FPU status CSR.

---
 rtl/fp_addsub_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// fp_addsub_arbiter
//
// Purpose:
//   Shares one combinational FP adder/subtractor among NUM_REQ requesters.
//   A round-robin arbiter grants one requester at a time. The granted operands
//   are held in registers that drive the unit for the whole operation. After
//   LAT cycles the result and flags are registered into a single-entry
//   response buffer tagged with the requester id. A sticky exception-flag
//   register accrues every captured flag set. It is the accrued-flags source
//   for the FPU status CSR.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready is one-hot)
//   req_a, req_b            64-bit operands, slice i = bits 64i+63:64i
//   req_sub, req_dp         per-requester subtract / double-precision select
//   req_rm                  3-bit rounding mode per requester
//   fu_*  (out)             operand/control registers feeding the unit
//   fu_result, fu_flags     unit outputs, flags = {invalid, overflow,
//                           underflow, inexact}
//   rsp_valid/rsp_ready     response handshake
//   rsp_id, rsp_result,     registered response, stable until accepted
//   rsp_flags
//   sticky_flags            accrued OR of all captured flags
//   flags_clr               synchronous clear of sticky_flags
//   busy                    high whenever an operation or response is pending
// -----------------------------------------------------------------------------
module fp_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*64-1:0]  req_a,
  input  logic [NUM_REQ*64-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_sub,
  input  logic [NUM_REQ-1:0]     req_dp,
  input  logic [NUM_REQ*3-1:0]   req_rm,

  output logic [63:0]            fu_operand_a,
  output logic [63:0]            fu_operand_b,
  output logic                   fu_is_subtraction,
  output logic                   fu_is_double_precision,
  output logic [2:0]             fu_rounding_mode,
  input  logic [63:0]            fu_result,
  input  logic [3:0]             fu_flags,

  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [63:0]            rsp_result,
  output logic [3:0]             rsp_flags,

  output logic [3:0]             sticky_flags,
  input  logic                   flags_clr,
  output logic                   busy
);

  // One extra bit so rr_ptr + k cannot wrap before the modulo correction.
  localparam int SCAN_W = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [63:0]       opa_q, opa_d;
  logic [63:0]       opb_q, opb_d;
  logic              sub_q, sub_d;
  logic              dp_q, dp_d;
  logic [2:0]        rm_q, rm_d;

  logic [63:0]       res_q, res_d;
  logic [3:0]        flg_q, flg_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [3:0]        sticky_q, sticky_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [SCAN_W-1:0] scan_idx;
  logic              capture;

  // Per-requester views of the flattened request buses.
  logic [63:0] a_slice  [NUM_REQ];
  logic [63:0] b_slice  [NUM_REQ];
  logic [2:0]  rm_slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign a_slice[i]  = req_a[64*i +: 64];
    assign b_slice[i]  = req_b[64*i +: 64];
    assign rm_slice[i] = req_rm[3*i +: 3];
  end

  // Round-robin pick: first valid index scanning from rr_ptr upward, wrapping
  // at NUM_REQ (which need not be a power of two).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + SCAN_W'(k);
      if (scan_idx >= SCAN_W'(NUM_REQ)) begin
        scan_idx = scan_idx - SCAN_W'(NUM_REQ);
      end
      if (!gnt_found && req_valid[scan_idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // The result is sampled on the last EXEC cycle, once the unit has had LAT
  // cycles to settle.
  assign capture = (state_q == S_EXEC) && (cnt_q == 4'd0);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sub_d     = sub_q;
    dp_d      = dp_q;
    rm_d      = rm_q;
    res_d     = res_q;
    flg_d     = flg_q;
    rid_d     = rid_q;
    req_ready = '0;

    unique case (state_q)
      S_IDLE: begin
        // Gated by rst_n so no grant is shown while reset is held.
        if (gnt_found && rst_n) begin
          req_ready[gnt_idx] = 1'b1;
          opa_d    = a_slice[gnt_idx];
          opb_d    = b_slice[gnt_idx];
          sub_d    = req_sub[gnt_idx];
          dp_d     = req_dp[gnt_idx];
          rm_d     = rm_slice[gnt_idx];
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          cnt_d    = 4'(LAT - 1);
          state_d  = S_EXEC;
        end
      end

      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = fu_result;
          flg_d   = fu_flags;
          rid_d   = id_q;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        // Return to IDLE only; arbitration resumes on the following cycle.
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A clear in the capture cycle wipes the old accrued bits but keeps the
  // flags of the operation completing in that cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (flags_clr) begin
      sticky_d = '0;
    end
    if (capture) begin
      sticky_d = sticky_d | fu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sub_q    <= 1'b0;
      dp_q     <= 1'b0;
      rm_q     <= '0;
      res_q    <= '0;
      flg_q    <= '0;
      rid_q    <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sub_q    <= sub_d;
      dp_q     <= dp_d;
      rm_q     <= rm_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
      rid_q    <= rid_d;
      sticky_q <= sticky_d;
    end
  end

  assign fu_operand_a           = opa_q;
  assign fu_operand_b           = opb_q;
  assign fu_is_subtraction      = sub_q;
  assign fu_is_double_precision = dp_q;
  assign fu_rounding_mode       = rm_q;

  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_id       = rid_q;
  assign rsp_result   = res_q;
  assign rsp_flags    = flg_q;
  assign sticky_flags = sticky_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_addsub_arbiter
//
// Directed bench for fp_addsub_arbiter. The shared FP unit is replaced by a
// small lookup model that knows the exact IEEE results of the directed vectors
// and returns a ^ b for any other operand pair. A second instance is built
// with LAT=1 and NUM_REQ=2.
// -----------------------------------------------------------------------------
module tb_fp_addsub_arbiter;

  localparam int LAT_MAIN = 2;

  logic         clk = 1'b0;
  logic         rst_n;

  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [3:0]   req_sub;
  logic [3:0]   req_dp;
  logic [11:0]  req_rm;
  logic [63:0]  fu_operand_a;
  logic [63:0]  fu_operand_b;
  logic         fu_is_subtraction;
  logic         fu_is_double_precision;
  logic [2:0]   fu_rounding_mode;
  logic [63:0]  fu_result;
  logic [3:0]   fu_flags;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_result;
  logic [3:0]   rsp_flags;
  logic [3:0]   sticky_flags;
  logic         flags_clr;
  logic         busy;

  logic [1:0]   d1_req_valid;
  logic [1:0]   d1_req_ready;
  logic [127:0] d1_req_a;
  logic [127:0] d1_req_b;
  logic [1:0]   d1_req_sub;
  logic [1:0]   d1_req_dp;
  logic [5:0]   d1_req_rm;
  logic [63:0]  d1_fu_operand_a;
  logic [63:0]  d1_fu_operand_b;
  logic         d1_fu_is_subtraction;
  logic         d1_fu_is_double_precision;
  logic [2:0]   d1_fu_rounding_mode;
  logic [63:0]  d1_fu_result;
  logic [3:0]   d1_fu_flags;
  logic         d1_rsp_valid;
  logic         d1_rsp_ready;
  logic [0:0]   d1_rsp_id;
  logic [63:0]  d1_rsp_result;
  logic [3:0]   d1_rsp_flags;
  logic [3:0]   d1_sticky_flags;
  logic         d1_flags_clr;
  logic         d1_busy;

  int n_checks = 0;
  int n_errors = 0;

  fp_addsub_arbiter #(.NUM_REQ(4), .LAT(LAT_MAIN)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_a                  (req_a),
    .req_b                  (req_b),
    .req_sub                (req_sub),
    .req_dp                 (req_dp),
    .req_rm                 (req_rm),
    .fu_operand_a           (fu_operand_a),
    .fu_operand_b           (fu_operand_b),
    .fu_is_subtraction      (fu_is_subtraction),
    .fu_is_double_precision (fu_is_double_precision),
    .fu_rounding_mode       (fu_rounding_mode),
    .fu_result              (fu_result),
    .fu_flags               (fu_flags),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_id                 (rsp_id),
    .rsp_result             (rsp_result),
    .rsp_flags              (rsp_flags),
    .sticky_flags           (sticky_flags),
    .flags_clr              (flags_clr),
    .busy                   (busy)
  );

  fp_addsub_arbiter #(.NUM_REQ(2), .LAT(1)) dut1 (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_valid              (d1_req_valid),
    .req_ready              (d1_req_ready),
    .req_a                  (d1_req_a),
    .req_b                  (d1_req_b),
    .req_sub                (d1_req_sub),
    .req_dp                 (d1_req_dp),
    .req_rm                 (d1_req_rm),
    .fu_operand_a           (d1_fu_operand_a),
    .fu_operand_b           (d1_fu_operand_b),
    .fu_is_subtraction      (d1_fu_is_subtraction),
    .fu_is_double_precision (d1_fu_is_double_precision),
    .fu_rounding_mode       (d1_fu_rounding_mode),
    .fu_result              (d1_fu_result),
    .fu_flags               (d1_fu_flags),
    .rsp_valid              (d1_rsp_valid),
    .rsp_ready              (d1_rsp_ready),
    .rsp_id                 (d1_rsp_id),
    .rsp_result             (d1_rsp_result),
    .rsp_flags              (d1_rsp_flags),
    .sticky_flags           (d1_sticky_flags),
    .flags_clr              (d1_flags_clr),
    .busy                   (d1_busy)
  );

  always #5 clk = ~clk;

  // Returns {flags, result}.
  function automatic logic [67:0] fu_model(input logic [63:0] a, input logic [63:0] b,
                                           input logic sub);
    if (!sub && a == 64'h3FF0000000000000 && b == 64'h4000000000000000)
      return {4'b0000, 64'h4008000000000000};   // 1.0 + 2.0 = 3.0
    if (!sub && a == 64'h7FEFFFFFFFFFFFFF && b == 64'h7FEFFFFFFFFFFFFF)
      return {4'b0101, 64'h7FF0000000000000};   // max + max -> +inf, OF|NX
    if (sub && a == 64'h7FF0000000000000 && b == 64'h7FF0000000000000)
      return {4'b1000, 64'h7FF8000000000000};   // inf - inf -> qNaN, NV
    return {4'b0000, a ^ b};
  endfunction

  always_comb {fu_flags, fu_result} = fu_model(fu_operand_a, fu_operand_b, fu_is_subtraction);
  always_comb {d1_fu_flags, d1_fu_result} =
    fu_model(d1_fu_operand_a, d1_fu_operand_b, d1_fu_is_subtraction);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from requester r on the main instance (called in IDLE,
  // one step after a clock edge) and check the whole transaction. When clr is
  // set, flags_clr is pulsed in the capture cycle.
  task automatic run_op(input int r, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic dp, input logic [2:0] rm,
                        input logic clr, input logic [63:0] exp_res,
                        input logic [3:0] exp_flg, input string tag);
    int lat;
    req_a[r*64 +: 64] = a;
    req_b[r*64 +: 64] = b;
    req_sub[r]        = sub;
    req_dp[r]         = dp;
    req_rm[r*3 +: 3]  = rm;
    req_valid         = 4'b0001 << r;
    #1;
    check_eq({tag, ".ready"}, 64'(req_ready), 64'(4'b0001 << r));
    tick();
    req_valid = '0;
    lat = 1;
    check_eq({tag, ".fu_a"}, fu_operand_a, a);
    check_eq({tag, ".fu_ctl"}, 64'({fu_is_subtraction, fu_is_double_precision, fu_rounding_mode}),
             64'({sub, dp, rm}));
    while (!rsp_valid && lat < 20) begin
      check_eq({tag, ".fu_b_stable"}, fu_operand_b, b);
      if (lat == LAT_MAIN) flags_clr = clr;
      tick();
      flags_clr = 1'b0;
      lat++;
    end
    check_eq({tag, ".latency"}, 64'(lat), 64'(LAT_MAIN + 1));
    check_eq({tag, ".rsp_id"}, 64'(rsp_id), 64'(r));
    check_eq({tag, ".rsp_result"}, rsp_result, exp_res);
    check_eq({tag, ".rsp_flags"}, 64'(rsp_flags), 64'(exp_flg));
    tick();
    check_eq({tag, ".idle_after"}, 64'(busy), 64'(0));
  endtask

  logic [63:0] rr_a [4];
  int          lat1;
  int          guard;

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    req_sub      = '0;
    req_dp       = '0;
    req_rm       = '0;
    rsp_ready    = 1'b1;
    flags_clr    = 1'b0;
    d1_req_valid = '0;
    d1_req_a     = '0;
    d1_req_b     = '0;
    d1_req_sub   = '0;
    d1_req_dp    = '0;
    d1_req_rm    = '0;
    d1_rsp_ready = 1'b1;
    d1_flags_clr = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst.req_ready", 64'(req_ready), 64'(0));
    check_eq("rst.busy", 64'(busy), 64'(0));
    check_eq("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst.fu_a", fu_operand_a, 64'(0));
    check_eq("rst.rsp_result", rsp_result, 64'(0));
    check_eq("rst.sticky", 64'(sticky_flags), 64'(0));
    check_eq("rst.d1", 64'({d1_busy, d1_rsp_valid, d1_sticky_flags, d1_rsp_flags}), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single op and flag accrual
    run_op(2, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 1'b1, 3'd0, 1'b0,
           64'h4008000000000000, 4'b0000, "single");
    check_eq("single.sticky", 64'(sticky_flags), 64'(0));
    run_op(0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 1'b1, 3'd0, 1'b0,
           64'h7FF0000000000000, 4'b0101, "ovf");
    check_eq("ovf.sticky", 64'(sticky_flags), 64'(4'b0101));
    run_op(1, 64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, 1'b1, 3'd0, 1'b0,
           64'h7FF8000000000000, 4'b1000, "nv");
    check_eq("nv.sticky", 64'(sticky_flags), 64'(4'b1101));
    run_op(3, 64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, 1'b1, 3'd2, 1'b1,
           64'h7FF8000000000000, 4'b1000, "nvclr");
    check_eq("nvclr.sticky", 64'(sticky_flags), 64'(4'b1000));
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check_eq("clr.sticky", 64'(sticky_flags), 64'(0));

    // Backpressure: requester 1 held in RESP while requester 3 waits
    rsp_ready      = 1'b0;
    req_a[64 +: 64] = 64'h1111;
    req_b[64 +: 64] = 64'h2222;
    req_sub[1]     = 1'b0;
    req_valid      = 4'b0010;
    #1;
    check_eq("bp.ready", 64'(req_ready), 64'(4'b0010));
    tick();
    req_a[192 +: 64] = 64'h10;
    req_b[192 +: 64] = 64'h01;
    req_sub[3]       = 1'b0;
    req_valid        = 4'b1000;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      tick();
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      check_eq("bp.rsp_valid", 64'(rsp_valid), 64'(1));
      check_eq("bp.busy", 64'(busy), 64'(1));
      check_eq("bp.no_grant", 64'(req_ready), 64'(0));
      check_eq("bp.result", rsp_result, 64'h3333);
      check_eq("bp.id", 64'(rsp_id), 64'(1));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp.release_valid", 64'(rsp_valid), 64'(1));
    tick();
    check_eq("bp.idle", 64'({busy, rsp_valid}), 64'(0));
    check_eq("bp.next_grant", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("bp2.id", 64'(rsp_id), 64'(3));
    check_eq("bp2.result", rsp_result, 64'h11);
    tick();

    // Reset in the middle of EXEC
    req_a[128 +: 64] = 64'h5;
    req_b[128 +: 64] = 64'h6;
    req_sub[2]       = 1'b0;
    req_valid        = 4'b0100;
    #1;
    check_eq("mid.ready", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    check_eq("mid.busy", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid.rst_busy", 64'(busy), 64'(0));
    check_eq("mid.rst_fu_a", fu_operand_a, 64'(0));
    check_eq("mid.rst_rsp", 64'({rsp_valid, rsp_id, rsp_flags}), 64'(0));
    check_eq("mid.rst_result", rsp_result, 64'(0));
    check_eq("mid.rst_ready", 64'(req_ready), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mid.no_stale", 64'({rsp_valid, busy}), 64'(0));
    end

    // Round-robin with all requesters held; pointer restarts at 0
    for (int i = 0; i < 4; i++) begin
      rr_a[i]            = 64'h100 * 64'(i + 1);
      req_a[i*64 +: 64]  = rr_a[i];
      req_b[i*64 +: 64]  = 64'h7;
      req_sub[i]         = 1'b0;
    end
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      guard = 0;
      while (req_ready == 4'b0000 && guard < 20) begin
        tick();
        guard++;
      end
      check_eq("rr.grant", 64'(req_ready), 64'(4'b0001 << (g % 4)));
      check_eq("rr.onehot", 64'($countones(req_ready)), 64'(1));
      tick();
      guard = 0;
      while (!rsp_valid && guard < 20) begin
        tick();
        guard++;
      end
      check_eq("rr.rsp_id", 64'(rsp_id), 64'(g % 4));
      check_eq("rr.result", rsp_result, rr_a[g % 4] ^ 64'h7);
    end
    req_valid = '0;
    tick();
    check_eq("rr.done", 64'(busy), 64'(0));

    // LAT=1 instance
    d1_req_a[64 +: 64] = 64'h3FF0000000000000;
    d1_req_b[64 +: 64] = 64'h4000000000000000;
    d1_req_sub[1]      = 1'b0;
    d1_req_dp[1]       = 1'b1;
    d1_req_rm[3 +: 3]  = 3'd1;
    d1_req_valid       = 2'b10;
    #1;
    check_eq("lat1.ready", 64'(d1_req_ready), 64'(2'b10));
    tick();
    d1_req_valid = '0;
    lat1 = 1;
    while (!d1_rsp_valid && lat1 < 20) begin
      check_eq("lat1.fu_a", d1_fu_operand_a, 64'h3FF0000000000000);
      check_eq("lat1.fu_ctl", 64'({d1_fu_is_double_precision, d1_fu_rounding_mode}), 64'(4'b1001));
      tick();
      lat1++;
    end
    check_eq("lat1.latency", 64'(lat1), 64'(2));
    check_eq("lat1.fu_b", d1_fu_operand_b, 64'h4000000000000000);
    check_eq("lat1.rsp_id", 64'(d1_rsp_id), 64'(1));
    check_eq("lat1.result", d1_rsp_result, 64'h4008000000000000);
    check_eq("lat1.flags", 64'({d1_rsp_flags, d1_sticky_flags}), 64'(0));
    tick();
    check_eq("lat1.idle", 64'(d1_busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
